// File: rtl/contador_checker.sv
// contador_checker: reference model and mismatch checker for the N-bit +1/-1/-3/load counter
module contador_checker #(
  parameter int N    = 4,
  parameter int ERRW = 8
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            iEN,
  input  logic [1:0]      iMODO,
  input  logic [N-1:0]    iD,
  input  logic [N-1:0]    iQ,
  input  logic            iRCO,
  output logic            oERR,
  output logic [ERRW-1:0] oERR_CNT,
  output logic            oSYNC,
  output logic [N-1:0]    oEXP_Q
);
  typedef enum logic [1:0] {IDLE, CHECK, RESYNC} state_t;
  state_t state_q, state_d;
  logic [N-1:0] m_q, m_d, base_m, m_nxt;
  logic e_q, e_d, base_e, e_nxt;
  logic err_q, err_d, load, mismatch;
  logic [ERRW-1:0] cnt_q, cnt_d;
  always_comb begin
    // after a mismatch the observed counter value becomes the new reference
    base_m   = state_q == RESYNC ? iQ : m_q;
    base_e   = state_q == RESYNC ? iRCO : e_q;
    load     = iEN && iMODO == 2'b11;
    mismatch = state_q == CHECK && (iQ != m_q || iRCO != e_q);
    m_nxt    = !iEN ? base_m :
               iMODO == 2'b00 ? base_m + N'(1) :
               iMODO == 2'b01 ? base_m - N'(1) :
               iMODO == 2'b10 ? base_m - N'(3) : iD;
    e_nxt    = !iEN ? base_e :
               iMODO == 2'b00 ? &base_m :
               iMODO == 2'b01 ? base_m == '0 :
               iMODO == 2'b10 ? base_m < N'(3) : 1'b0;
    state_d  = state_q == IDLE ? (load ? CHECK : IDLE) :
               state_q == CHECK ? (mismatch && !load ? RESYNC : CHECK) : CHECK;
    m_d      = state_q == IDLE ? (load ? iD : m_q) : m_nxt;
    e_d      = state_q == IDLE ? (load ? 1'b0 : e_q) : e_nxt;
    err_d    = mismatch;
    cnt_d    = mismatch && !(&cnt_q) ? cnt_q + ERRW'(1) : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign oERR     = err_q;
  assign oERR_CNT = cnt_q;
  assign oSYNC    = state_q == CHECK;
  assign oEXP_Q   = m_q;
endmodule
